pwm_meas: RTL and testbench
===========================

// Module: pwm_meas
// PURPOSE
//  Downstream QC monitor for one PWM generator output. Measures period and high time of the
//  PWM waveform in clk_axi cycles and publishes results to read-only status registers.
//  Detects stuck-low/stuck-high outputs (0%/100% duty or dead channel) via timeout.
//  One instance per PWM0..PWM5, wired back into the register file.
// PARAMETERS
//  CNT_W        32       width of period/high counters and results
//  SYNC_STAGES  2        flops in pwm_in synchronizer (>=2)
//  TIMEOUT_CYC  2**20    cycles without a rising edge before timeout; must be <= 2**CNT_W-1
// PORTS
//  clk_axi      in   1       system clock, all logic on rising edge
//  rstn_axi     in   1       synchronous reset, active-low
//  enable       in   1       measurement enable (level)
//  clear        in   1       one-cycle pulse: zero results, count, sticky flags
//  pwm_in       in   1       PWM waveform under test (treated as asynchronous)
//  period_cnt   out  CNT_W   last measured period, cycles rising->rising
//  high_cnt     out  CNT_W   last measured high time, cycles
//  meas_valid   out  1       one-cycle pulse when period_cnt/high_cnt update
//  meas_count   out  16      number of completed measurements, wraps 0xFFFF->0
//  timeout      out  1       sticky: TIMEOUT_CYC elapsed with no rising edge
//  stuck_level  out  1       synchronized pwm_in level captured at last timeout
// BEHAVIOUR
//  - Reset (rstn_axi=0 at clk edge): all outputs 0, FSM=IDLE, sync flops 0.
//  - pwm_in passes SYNC_STAGES flops -> pwm_s; rise = pwm_s & ~pwm_s_d (one extra flop).
//  - FSM: IDLE  : enable=0; counters held at 0. enable=1 -> ARM.
//         ARM   : wait for rise; on rise cnt<=1, hi<=1, -> MEAS.
//         MEAS  : each cycle cnt<=cnt+1, hi<=hi+pwm_s. On rise: period_cnt<=cnt,
//                 high_cnt<=hi, meas_valid<=1, meas_count++, cnt<=1, hi<=1, stay MEAS.
//                 cnt==TIMEOUT_CYC and no rise: timeout<=1, stuck_level<=pwm_s, -> ARM.
//         any state: enable=0 -> IDLE next cycle; results/flags held.
//  - Latency: pin edge sampled at cycle N -> rise at N+SYNC_STAGES -> meas_valid at N+SYNC_STAGES+1.
//  - First rise after ARM never produces meas_valid (no full period yet).
//  - Arithmetic: unsigned; cnt/hi cannot overflow given TIMEOUT_CYC constraint; hi <= cnt always.
//  - clear: period_cnt, high_cnt, meas_count, timeout, stuck_level <= 0; FSM -> ARM if enable
//    else IDLE; takes priority over a coincident rise (that edge is dropped) and over enable change.
//  - rise and timeout same cycle: rise wins, no timeout.
//  - timeout stays 1 until clear or reset, even after valid measurements resume.
//  - Reset mid-measurement: partial counts discarded, no meas_valid.
// STRUCTURE
//  - pwm_pkg: CNT_W default, state encoding (IDLE=2'd0, ARM=2'd1, MEAS=2'd2), TIMEOUT default.
//  - Sub-module sync_rise_det (SYNC_STAGES synchronizer + rising-edge detect), outputs pwm_s, rise.
//  - pwm_meas holds FSM, cnt/hi counters, result/status registers.
// TESTING
//  1 enable=1, pwm_in period 8 cycles high 4 -> after 2nd rise meas_valid pulses, period_cnt=8,
//    high_cnt=4; meas_count increments by 1 per period.
//  2 period 10 high 1, then period 10 high 9 -> high_cnt=1 then 9, period_cnt=10 throughout.
//  3 TIMEOUT_CYC=64, pwm_in held 1 -> timeout=1 at 64 cycles after last rise, stuck_level=1;
//    held 0 from reset with enable -> no timeout (ARM has no counter), meas_valid never.
//  4 clear pulse on same cycle as rise -> all results 0, no meas_valid for next 2 rises' first.
//  5 enable dropped mid-period then restored -> no meas_valid for aborted period; first
//    valid result after 2 rises with correct values.
//  6 rstn_axi=0 for 1 cycle mid-MEAS -> outputs 0 next cycle; resumes via ARM.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared defaults and FSM state encoding for the PWM measurement monitor
// Contents: default counter width, synchronizer depth, timeout length, and the
// measurement FSM state type used by pwm_meas.
package pwm_pkg;

    localparam int CNT_W_DEF       = 32;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int TIMEOUT_DEF     = 2**20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

endpackage

// File: rtl/sync_rise_det.sv
// rtl/sync_rise_det.sv - multi-flop synchronizer with rising-edge detect
// Ports:
//   clk    in   system clock
//   rstn   in   synchronous active-low reset
//   din    in   asynchronous input
//   pwm_s  out  synchronized level
//   rise   out  one-cycle pulse on a 0->1 transition of pwm_s
module sync_rise_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic din,
    output logic pwm_s,
    output logic rise
);

    logic [STAGES-1:0] sync;
    logic              pwm_s_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync    <= '0;
            pwm_s_d <= 1'b0;
        end else begin
            sync    <= {sync[STAGES-2:0], din};
            pwm_s_d <= sync[STAGES-1];
        end
    end

    assign pwm_s = sync[STAGES-1];
    assign rise  = pwm_s & ~pwm_s_d;

endmodule

// File: rtl/pwm_meas.sv
// rtl/pwm_meas.sv - PWM period/high-time monitor with stuck-output timeout
// Ports:
//   clk_axi      in   system clock
//   rstn_axi     in   synchronous active-low reset
//   enable       in   measurement enable (level)
//   clear        in   one-cycle pulse: zero results, count and sticky flags
//   pwm_in       in   asynchronous PWM waveform under test
//   period_cnt   out  last measured period (cycles, rise to rise)
//   high_cnt     out  last measured high time (cycles)
//   meas_valid   out  one-cycle pulse when period_cnt/high_cnt update
//   meas_count   out  completed measurement count, wraps
//   timeout      out  sticky: no rising edge for TIMEOUT_CYC cycles
//   stuck_level  out  synchronized pwm level captured at the last timeout
module pwm_meas
    import pwm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic             clk_axi,
    input  logic             rstn_axi,
    input  logic             enable,
    input  logic             clear,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic [15:0]      meas_count,
    output logic             timeout,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic             pwm_s;
    logic             rise;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi;

    sync_rise_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk_axi),
        .rstn  (rstn_axi),
        .din   (pwm_in),
        .pwm_s (pwm_s),
        .rise  (rise)
    );

    always_ff @(posedge clk_axi) begin
        if (!rstn_axi) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            hi          <= '0;
            period_cnt  <= '0;
            high_cnt    <= '0;
            meas_valid  <= 1'b0;
            meas_count  <= '0;
            timeout     <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (clear) begin
                // Clear beats a coincident rise: that edge is dropped and the
                // FSM re-arms, so the next full period starts from scratch.
                period_cnt  <= '0;
                high_cnt    <= '0;
                meas_count  <= '0;
                timeout     <= 1'b0;
                stuck_level <= 1'b0;
                cnt         <= '0;
                hi          <= '0;
                state       <= enable ? ST_ARM : ST_IDLE;
            end else if (!enable) begin
                // Abandon any partial period; results and flags are kept.
                state <= ST_IDLE;
                cnt   <= '0;
                hi    <= '0;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_ARM;
                    ST_ARM: begin
                        if (rise) begin
                            cnt   <= ONE;
                            hi    <= ONE;
                            state <= ST_MEAS;
                        end
                    end
                    ST_MEAS: begin
                        if (rise) begin
                            period_cnt <= cnt;
                            high_cnt   <= hi;
                            meas_valid <= 1'b1;
                            meas_count <= meas_count + 16'd1;
                            cnt        <= ONE;
                            hi         <= ONE;
                        end else if (cnt == TIMEOUT_V) begin
                            timeout     <= 1'b1;
                            stuck_level <= pwm_s;
                            cnt         <= '0;
                            hi          <= '0;
                            state       <= ST_ARM;
                        end else begin
                            cnt <= cnt + ONE;
                            hi  <= hi + {{(CNT_W-1){1'b0}}, pwm_s};
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_meas.sv
// tb/tb_pwm_meas.sv - directed self-checking bench for pwm_meas
module tb_pwm_meas;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic        clear;
    logic        pwm_in;
    logic [31:0] period_cnt;
    logic [31:0] high_cnt;
    logic        meas_valid;
    logic [15:0] meas_count;
    logic        timeout;
    logic        stuck_level;

    int tests;
    int fails;
    int vcnt;
    logic [31:0] last_p;
    logic [31:0] last_h;

    pwm_meas #(
        .CNT_W       (32),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk_axi     (clk),
        .rstn_axi    (rstn),
        .enable      (enable),
        .clear       (clear),
        .pwm_in      (pwm_in),
        .period_cnt  (period_cnt),
        .high_cnt    (high_cnt),
        .meas_valid  (meas_valid),
        .meas_count  (meas_count),
        .timeout     (timeout),
        .stuck_level (stuck_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstn && meas_valid) begin
            vcnt   = vcnt + 1;
            last_p = period_cnt;
            last_h = high_cnt;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pwm_cycles(input int period, input int high, input int n);
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < period; i++) begin
                pwm_in = (i < high);
                tick();
            end
        end
    endtask

    task automatic restart();
        enable = 1'b0;
        pwm_in = 1'b0;
        repeat (4) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        enable = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0; enable = 1'b0; clear = 1'b0; pwm_in = 1'b0;
        repeat (3) tick();
        tests++; if (period_cnt !== 32'd0) begin fails++; $display("FAIL reset_period got %0d want 0", period_cnt); end
        tests++; if (high_cnt !== 32'd0) begin fails++; $display("FAIL reset_high got %0d want 0", high_cnt); end
        tests++; if (meas_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", meas_valid); end
        tests++; if (meas_count !== 16'd0) begin fails++; $display("FAIL reset_count got %0d want 0", meas_count); end
        tests++; if (timeout !== 1'b0 || stuck_level !== 1'b0) begin fails++; $display("FAIL reset_flags got %0b%0b want 00", timeout, stuck_level); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int v0;
        restart();
        v0 = vcnt;
        pwm_cycles(8, 4, 5);
        repeat (4) tick();
        tests++; if (vcnt - v0 !== 4) begin fails++; $display("FAIL basic_pulses got %0d want 4", vcnt - v0); end
        tests++; if (meas_count !== 16'd4) begin fails++; $display("FAIL basic_count got %0d want 4", meas_count); end
        tests++; if (period_cnt !== 32'd8) begin fails++; $display("FAIL basic_period got %0d want 8", period_cnt); end
        tests++; if (high_cnt !== 32'd4) begin fails++; $display("FAIL basic_high got %0d want 4", high_cnt); end
        tests++; if (last_p !== 32'd8 || last_h !== 32'd4) begin fails++; $display("FAIL basic_at_pulse got %0d/%0d want 8/4", last_p, last_h); end
    endtask

    task automatic test_duty();
        int v0;
        restart();
        v0 = vcnt;
        pwm_cycles(10, 1, 4);
        tests++; if (high_cnt !== 32'd1) begin fails++; $display("FAIL duty_low_high got %0d want 1", high_cnt); end
        tests++; if (period_cnt !== 32'd10) begin fails++; $display("FAIL duty_low_period got %0d want 10", period_cnt); end
        pwm_cycles(10, 9, 4);
        tests++; if (high_cnt !== 32'd9) begin fails++; $display("FAIL duty_high_high got %0d want 9", high_cnt); end
        tests++; if (period_cnt !== 32'd10) begin fails++; $display("FAIL duty_high_period got %0d want 10", period_cnt); end
        tests++; if (meas_count !== 16'd7) begin fails++; $display("FAIL duty_count got %0d want 7", meas_count); end
        tests++; if (vcnt - v0 !== 7) begin fails++; $display("FAIL duty_pulses got %0d want 7", vcnt - v0); end
    endtask

    task automatic test_timeout();
        int v1;
        int v2;
        restart();
        pwm_cycles(8, 4, 2);
        pwm_in = 1'b1;
        repeat (60) tick();
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL timeout_early got %0b want 0", timeout); end
        repeat (10) tick();
        tests++; if (timeout !== 1'b1) begin fails++; $display("FAIL timeout_set got %0b want 1", timeout); end
        tests++; if (stuck_level !== 1'b1) begin fails++; $display("FAIL timeout_level got %0b want 1", stuck_level); end
        v1 = vcnt;
        pwm_cycles(8, 4, 4);
        tests++; if (vcnt - v1 !== 2) begin fails++; $display("FAIL timeout_resume_pulses got %0d want 2", vcnt - v1); end
        tests++; if (timeout !== 1'b1) begin fails++; $display("FAIL timeout_sticky got %0b want 1", timeout); end
        tests++; if (period_cnt !== 32'd8 || high_cnt !== 32'd4) begin fails++; $display("FAIL timeout_resume_vals got %0d/%0d want 8/4", period_cnt, high_cnt); end
        restart();
        tests++; if (timeout !== 1'b0 || stuck_level !== 1'b0) begin fails++; $display("FAIL timeout_clear got %0b%0b want 00", timeout, stuck_level); end
        v2 = vcnt;
        repeat (100) tick();
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL timeout_low_arm got %0b want 0", timeout); end
        tests++; if (vcnt !== v2 || meas_count !== 16'd0) begin fails++; $display("FAIL timeout_low_valid got %0d/%0d want 0/0", vcnt - v2, meas_count); end
    endtask

    task automatic test_clear_on_rise();
        int v0;
        restart();
        pwm_cycles(8, 4, 3);
        tests++; if (meas_count !== 16'd2) begin fails++; $display("FAIL clr_pre_count got %0d want 2", meas_count); end
        v0 = vcnt;
        // Pin rises after edge E; the FSM sees it at edge E+3, where clear is sampled.
        pwm_in = 1'b1;
        tick();
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        pwm_in = 1'b0;
        repeat (4) tick();
        tests++; if (period_cnt !== 32'd0 || high_cnt !== 32'd0) begin fails++; $display("FAIL clr_results got %0d/%0d want 0/0", period_cnt, high_cnt); end
        tests++; if (meas_count !== 16'd0) begin fails++; $display("FAIL clr_count got %0d want 0", meas_count); end
        tests++; if (vcnt !== v0) begin fails++; $display("FAIL clr_dropped_edge got %0d pulses want 0", vcnt - v0); end
        pwm_cycles(8, 4, 3);
        tests++; if (vcnt - v0 !== 2) begin fails++; $display("FAIL clr_after_pulses got %0d want 2", vcnt - v0); end
        tests++; if (meas_count !== 16'd2) begin fails++; $display("FAIL clr_after_count got %0d want 2", meas_count); end
        tests++; if (period_cnt !== 32'd8 || high_cnt !== 32'd4) begin fails++; $display("FAIL clr_after_vals got %0d/%0d want 8/4", period_cnt, high_cnt); end
    endtask

    task automatic test_enable_drop();
        int v0;
        restart();
        pwm_cycles(8, 4, 2);
        v0 = vcnt;
        pwm_in = 1'b1;
        repeat (4) tick();
        pwm_in = 1'b0;
        tick();
        enable = 1'b0;
        repeat (2) tick();
        tests++; if (period_cnt !== 32'd8 || meas_count !== 16'd2) begin fails++; $display("FAIL en_hold got %0d/%0d want 8/2", period_cnt, meas_count); end
        enable = 1'b1;
        tick();
        pwm_cycles(8, 4, 3);
        tests++; if (vcnt - v0 !== 3) begin fails++; $display("FAIL en_pulses got %0d want 3", vcnt - v0); end
        tests++; if (meas_count !== 16'd4) begin fails++; $display("FAIL en_count got %0d want 4", meas_count); end
        tests++; if (period_cnt !== 32'd8 || high_cnt !== 32'd4) begin fails++; $display("FAIL en_vals got %0d/%0d want 8/4", period_cnt, high_cnt); end
    endtask

    task automatic test_reset_mid();
        int v0;
        restart();
        pwm_cycles(8, 4, 2);
        pwm_in = 1'b1;
        repeat (4) tick();
        pwm_in = 1'b0;
        repeat (2) tick();
        tests++; if (meas_count !== 16'd2) begin fails++; $display("FAIL rstmid_pre_count got %0d want 2", meas_count); end
        rstn = 1'b0;
        tick();
        tests++; if (period_cnt !== 32'd0 || high_cnt !== 32'd0) begin fails++; $display("FAIL rstmid_results got %0d/%0d want 0/0", period_cnt, high_cnt); end
        tests++; if (meas_count !== 16'd0 || meas_valid !== 1'b0) begin fails++; $display("FAIL rstmid_count got %0d/%0b want 0/0", meas_count, meas_valid); end
        rstn = 1'b1;
        repeat (2) tick();
        v0 = vcnt;
        pwm_cycles(8, 4, 3);
        tests++; if (vcnt - v0 !== 2) begin fails++; $display("FAIL rstmid_pulses got %0d want 2", vcnt - v0); end
        tests++; if (meas_count !== 16'd2) begin fails++; $display("FAIL rstmid_count_after got %0d want 2", meas_count); end
        tests++; if (period_cnt !== 32'd8 || high_cnt !== 32'd4) begin fails++; $display("FAIL rstmid_vals got %0d/%0d want 8/4", period_cnt, high_cnt); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        vcnt  = 0;
        last_p = '0;
        last_h = '0;
        rstn = 1'b0; enable = 1'b0; clear = 1'b0; pwm_in = 1'b0;
        test_reset();
        test_basic();
        test_duty();
        test_timeout();
        test_clear_on_rise();
        test_enable_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
